// File: rtl/frame_decoder_if.sv
// Byte-stream and payload-reader signals of the frame decoder.
// The bench drives it through master; the decoder uses slave.
interface frame_decoder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] msg_data;
    logic       msg_ready;
    logic       msg_rd_en;
    logic       frame_ok;
    logic       frame_bad;
    logic [3:0] ack_seq;
    logic [7:0] err_cnt;

    modport master (
        output in_data, in_valid, msg_rd_en,
        input  msg_data, msg_ready, frame_ok, frame_bad, ack_seq, err_cnt
    );

    modport slave (
        input  in_data, in_valid, msg_rd_en,
        output msg_data, msg_ready, frame_ok, frame_bad, ack_seq, err_cnt
    );
endinterface

// File: rtl/frame_decoder.sv
// UART frame decoder: len/seq/payload/CRC16/0x7E parser that stages payload in a ring
// and exposes it to the reader only once the whole frame has been checked.
module frame_decoder #(
    parameter int RING_BITS = 8,
    parameter int MAX_LEN   = 64
) (
    input  logic            clk,
    input  logic            rst,
    frame_decoder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_SOF  = 3'd0,
        ST_SEQ  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC1 = 3'd3,
        ST_CRC2 = 3'd4,
        ST_EOF  = 3'd5,
        ST_SYNC = 3'd6
    } state_t;

    localparam int                   LP_DEPTH   = 1 << RING_BITS;
    localparam logic [8:0]           LP_MAX_LEN = 9'(MAX_LEN);
    localparam logic [RING_BITS-1:0] LP_ONE     = RING_BITS'(1);
    localparam logic [7:0]           LP_FLAG    = 8'h7E;

    // CRC16-CCITT, reflected polynomial, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic [7:0]           r_len;
    logic [7:0]           r_remain;
    logic [7:0]           r_seq;
    logic [15:0]          r_crc;
    logic [7:0]           r_crc_hi;
    logic [7:0]           r_crc_lo;
    logic [RING_BITS-1:0] r_wptr;
    logic [RING_BITS-1:0] r_rptr;
    logic [RING_BITS-1:0] r_temp_wptr;
    logic [3:0]           r_ack_seq;
    logic [7:0]           r_err_cnt;
    logic                 r_frame_ok;
    logic                 r_frame_bad;
    logic [7:0]           r_ring [LP_DEPTH];

    logic                 w_commit;
    logic                 w_discard;
    logic                 w_wr;
    logic                 w_ld_len;
    logic                 w_len_bad;
    logic                 w_ring_full;
    logic                 w_is_flag;
    logic                 w_msg_ready;
    logic [15:0]          w_crc_seed;
    logic [15:0]          w_crc_next;
    logic [RING_BITS-1:0] w_temp_inc;

    assign w_is_flag   = (bus.in_data == LP_FLAG);
    assign w_len_bad   = ({1'b0, bus.in_data} < 9'd5) || ({1'b0, bus.in_data} >= LP_MAX_LEN);
    assign w_temp_inc  = r_temp_wptr + LP_ONE;
    assign w_ring_full = (w_temp_inc == r_rptr);
    assign w_crc_seed  = (r_state == ST_SOF) ? 16'hFFFF : r_crc;
    assign w_crc_next  = crc16_byte(w_crc_seed, bus.in_data);
    assign w_msg_ready = (r_rptr != r_wptr);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SOF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-byte control decode
    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_discard    = 1'b0;
        w_wr         = 1'b0;
        w_ld_len     = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                ST_SOF: begin
                    if (w_is_flag) begin
                        w_next_state = ST_SOF;
                    end else if (w_len_bad) begin
                        w_discard = 1'b1;
                    end else begin
                        w_ld_len     = 1'b1;
                        w_next_state = ST_SEQ;
                    end
                end
                ST_SEQ:  w_next_state = (r_len == 8'd5) ? ST_CRC1 : ST_DATA;
                ST_DATA: begin
                    if (w_ring_full) begin
                        w_discard = 1'b1;
                    end else begin
                        w_wr         = 1'b1;
                        w_next_state = (r_remain == 8'd1) ? ST_CRC1 : ST_DATA;
                    end
                end
                ST_CRC1: w_next_state = ST_CRC2;
                ST_CRC2: w_next_state = ST_EOF;
                ST_EOF: begin
                    if (w_is_flag && ({r_crc_hi, r_crc_lo} == r_crc) && (r_seq[7:4] == 4'h1)) begin
                        w_commit     = 1'b1;
                        w_next_state = ST_SOF;
                    end else begin
                        w_discard = 1'b1;
                    end
                end
                ST_SYNC: w_next_state = w_is_flag ? ST_SOF : ST_SYNC;
                default: w_next_state = ST_SOF;
            endcase
            // A discard on the flag byte has already found the next frame boundary
            if (w_discard) begin
                w_next_state = w_is_flag ? ST_SOF : ST_SYNC;
            end else begin
                w_next_state = w_next_state;
            end
        end else begin
            w_next_state = r_state;
        end
    end

    // Frame parsing datapath: header, running CRC and staging pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= 8'd0;
            r_remain    <= 8'd0;
            r_seq       <= 8'd0;
            r_crc       <= 16'hFFFF;
            r_crc_hi    <= 8'd0;
            r_crc_lo    <= 8'd0;
            r_temp_wptr <= '0;
        end else begin
            if (w_ld_len) begin
                r_len       <= bus.in_data;
                r_remain    <= bus.in_data - 8'd5;
                r_crc       <= w_crc_next;
                r_temp_wptr <= r_wptr;
            end
            if (bus.in_valid && (r_state == ST_SEQ)) begin
                r_seq <= bus.in_data;
                r_crc <= w_crc_next;
            end
            if (w_wr) begin
                r_temp_wptr <= w_temp_inc;
                r_remain    <= r_remain - 8'd1;
                r_crc       <= w_crc_next;
            end
            if (bus.in_valid && (r_state == ST_CRC1)) begin
                r_crc_hi <= bus.in_data;
            end
            if (bus.in_valid && (r_state == ST_CRC2)) begin
                r_crc_lo <= bus.in_data;
            end
            if (w_discard) begin
                r_temp_wptr <= r_wptr;
            end
        end
    end

    // Committed pointers, status pulses and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ack_seq   <= 4'd0;
            r_err_cnt   <= 8'd0;
            r_frame_ok  <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            r_frame_ok  <= w_commit;
            r_frame_bad <= w_discard;
            if (w_commit) begin
                r_wptr    <= r_temp_wptr;
                r_ack_seq <= r_seq[3:0];
            end
            if (w_discard && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (bus.msg_rd_en && w_msg_ready) begin
                r_rptr <= r_rptr + LP_ONE;
            end
        end
    end

    // Payload ring storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ring[r_temp_wptr] <= bus.in_data;
        end
    end

    assign bus.msg_data  = r_ring[r_rptr];
    assign bus.msg_ready = w_msg_ready;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.frame_bad = r_frame_bad;
    assign bus.ack_seq   = r_ack_seq;
    assign bus.err_cnt   = r_err_cnt;

endmodule
